// File: rtl/bin2bcd_loader_pkg.sv
// Shared constants for the binary-to-BCD loader: FSM state encoding and
// the BCD digit limits used by the shift-add-3 correction.
package bin2bcd_loader_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SHIFT = 2'd1,
      DONE  = 2'd2
   } state_t;

   localparam logic [3:0] BCD_DIGIT_MAX   = 4'd9;
   localparam logic [3:0] BCD_ADD3_THRESH = 4'd5;
   localparam logic [3:0] BCD_ADD3_VAL    = 4'd3;

endpackage

// File: rtl/bin2bcd_loader_add3.sv
// Single-digit shift-add-3 corrector: a digit of 5 or more gets 3 added
// (mod 16) so that the following left shift carries correctly into the
// next decimal digit.
module bcd_add3
   import bin2bcd_loader_pkg::*;
(
   input  logic [3:0] din,
   output logic [3:0] dout
);

   // add 3 when the digit would reach 10 or more after doubling
   always_comb begin
      dout = din;
      if (din >= BCD_ADD3_THRESH) begin
         dout = din + BCD_ADD3_VAL;
      end
   end

endmodule

// File: rtl/bin2bcd_loader.sv
// Sequential binary-to-BCD converter feeding the parallel-load side of a
// chained BCD digit counter. One conversion takes BIN_WIDTH shift cycles
// plus one DONE cycle in which Load strobes the freshly registered BcdOut.
//
//   state | meaning
//   ------+----------------------------------------------------------
//   IDLE  | waiting for Start; BcdOut/Overflow hold the last result
//   SHIFT | one add-3-then-shift step per cycle, bit counter running
//   DONE  | result registered; Load high for exactly this one cycle
module bin2bcd_loader
   import bin2bcd_loader_pkg::*;
#(
   parameter int BIN_WIDTH = 8,
   parameter int DIGITS    = 3
) (
   input  logic                  CLK,
   input  logic                  RST,
   input  logic [BIN_WIDTH-1:0]  BinValue,
   input  logic                  Start,
   output logic                  Busy,
   output logic                  Load,
   output logic [4*DIGITS-1:0]   BcdOut,
   output logic                  Overflow
);

   localparam int BCD_W = 4 * DIGITS;
   localparam int CNT_W = $clog2(BIN_WIDTH + 1);

   state_t               state_q, state_d;
   logic [BCD_W-1:0]     bcd_q, bcd_corr, bcd_nxt, bcd_sat;
   logic [BIN_WIDTH-1:0] bin_q, bin_nxt;
   logic [CNT_W-1:0]     cnt_q;
   logic                 ovf_q, ovf_nxt;
   logic                 last_shift;

   for (genvar g = 0; g < DIGITS; g++) begin : g_digit
      bcd_add3 u_add3 (
         .din  (bcd_q[4*g +: 4]),
         .dout (bcd_corr[4*g +: 4])
      );
      assign bcd_sat[4*g +: 4] = BCD_DIGIT_MAX;
   end

   // one conversion step: corrected digits and binary shift left as one vector;
   // the bit falling off the top digit means the value does not fit
   always_comb begin
      {bcd_nxt, bin_nxt} = {bcd_corr, bin_q} << 1;
      ovf_nxt            = ovf_q | bcd_corr[BCD_W-1];
      last_shift         = (cnt_q == CNT_W'(1));
   end

   // state register
   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // next-state logic; Start only matters in IDLE
   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (Start) state_d = SHIFT;
         SHIFT:   if (last_shift) state_d = DONE;
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   assign Busy = (state_q != IDLE);
   assign Load = (state_q == DONE);

   // datapath: capture on accept, shift in SHIFT, register the result on the
   // final shift so it is valid throughout the DONE cycle
   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) begin
         bin_q    <= '0;
         bcd_q    <= '0;
         ovf_q    <= 1'b0;
         cnt_q    <= '0;
         BcdOut   <= '0;
         Overflow <= 1'b0;
      end else begin
         case (state_q)
            IDLE: begin
               if (Start) begin
                  bin_q <= BinValue;
                  bcd_q <= '0;
                  ovf_q <= 1'b0;
                  cnt_q <= CNT_W'(BIN_WIDTH);
               end
            end
            SHIFT: begin
               bin_q <= bin_nxt;
               bcd_q <= bcd_nxt;
               ovf_q <= ovf_nxt;
               cnt_q <= cnt_q - 1'b1;
               if (last_shift) begin
                  BcdOut   <= ovf_nxt ? bcd_sat : bcd_nxt;
                  Overflow <= ovf_nxt;
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_bin2bcd_loader.sv
// Bench for bin2bcd_loader: a 3-digit and a 2-digit instance share clock and
// reset; results are compared against a decimal-arithmetic reference.
module tb_bin2bcd_loader;

   localparam int BW = 8;

   logic        CLK = 1'b0;
   logic        RST = 1'b0;

   logic        start_a = 1'b0;
   logic [7:0]  bin_a   = '0;
   logic        busy_a, load_a, ovf_a;
   logic [11:0] bcd_a;

   logic        start_b = 1'b0;
   logic [7:0]  bin_b   = '0;
   logic        busy_b, load_b, ovf_b;
   logic [7:0]  bcd_b;

   int vectors    = 0;
   int miscompares = 0;

   int load_cnt_a = 0, load_cnt_b = 0;
   int dbl_load   = 0;
   int bad_chg    = 0;
   logic        prev_load_a = 1'b0, prev_load_b = 1'b0, prev_rst = 1'b0;
   logic [11:0] prev_bcd_a = '0;
   logic [7:0]  prev_bcd_b = '0;

   bin2bcd_loader #(.BIN_WIDTH(BW), .DIGITS(3)) dut_a (
      .CLK(CLK), .RST(RST), .BinValue(bin_a), .Start(start_a),
      .Busy(busy_a), .Load(load_a), .BcdOut(bcd_a), .Overflow(ovf_a)
   );

   bin2bcd_loader #(.BIN_WIDTH(BW), .DIGITS(2)) dut_b (
      .CLK(CLK), .RST(RST), .BinValue(bin_b), .Start(start_b),
      .Busy(busy_b), .Load(load_b), .BcdOut(bcd_b), .Overflow(ovf_b)
   );

   always #5 CLK = ~CLK;

   // pulse bookkeeping: Load pulse counts, back-to-back Load, BcdOut changing without Load
   always @(negedge CLK) begin
      if (load_a) load_cnt_a++;
      if (load_b) load_cnt_b++;
      if (load_a && prev_load_a) dbl_load++;
      if (load_b && prev_load_b) dbl_load++;
      if (RST && prev_rst) begin
         if (bcd_a !== prev_bcd_a && !load_a) bad_chg++;
         if (bcd_b !== prev_bcd_b && !load_b) bad_chg++;
      end
      prev_load_a = load_a;
      prev_load_b = load_b;
      prev_bcd_a  = bcd_a;
      prev_bcd_b  = bcd_b;
      prev_rst    = RST;
   end

   // decimal reference: digits by division, saturate to all nines when too big
   function automatic logic [11:0] ref_bcd(input int v, input int digits, output bit ovf);
      logic [11:0] r;
      int lim, x;
      r   = '0;
      lim = 1;
      for (int d = 0; d < digits; d++) lim = lim * 10;
      ovf = (v >= lim);
      x   = v;
      for (int d = 0; d < digits; d++) begin
         r[4*d +: 4] = ovf ? 4'd9 : 4'(x % 10);
         x = x / 10;
      end
      return r;
   endfunction

   task automatic drive(input bit sel, input logic s, input logic [7:0] v);
      if (sel) begin start_b = s; bin_b = v; end
      else     begin start_a = s; bin_a = v; end
   endtask

   // one conversion with cycle-exact Busy/Load checks; optional Start pulses
   // during SHIFT and DONE that must be ignored
   task automatic run_conv(input bit sel, input logic [7:0] v, input bit disturb, input string tag);
      logic [11:0] exp_bcd, got_bcd;
      bit          exp_ovf;
      logic        got_busy, got_load, got_ovf;
      int          lc0, lc1;
      exp_bcd = ref_bcd(int'(v), sel ? 2 : 3, exp_ovf);
      lc0     = sel ? load_cnt_b : load_cnt_a;
      drive(sel, 1'b1, v);
      for (int i = 0; i <= BW + 1; i++) begin
         @(negedge CLK);
         got_busy = sel ? busy_b : busy_a;
         got_load = sel ? load_b : load_a;
         got_bcd  = sel ? {4'h0, bcd_b} : bcd_a;
         got_ovf  = sel ? ovf_b : ovf_a;
         vectors++;
         if (got_busy !== (i <= BW)) begin
            miscompares++;
            $display("FAIL %s busy cycle %0d: got %b want %b", tag, i, got_busy, (i <= BW));
         end
         vectors++;
         if (got_load !== (i == BW)) begin
            miscompares++;
            $display("FAIL %s load cycle %0d: got %b want %b", tag, i, got_load, (i == BW));
         end
         if (i == BW) begin
            vectors++;
            if (got_bcd !== exp_bcd) begin
               miscompares++;
               $display("FAIL %s bcd for %0d: got %h want %h", tag, v, got_bcd, exp_bcd);
            end
            vectors++;
            if (got_ovf !== exp_ovf) begin
               miscompares++;
               $display("FAIL %s overflow for %0d: got %b want %b", tag, v, got_ovf, exp_ovf);
            end
         end
         if (i == 0)                 drive(sel, 1'b0, v);
         if (disturb && i == 2)      drive(sel, 1'b1, 8'd99);
         if (disturb && i == 3)      drive(sel, 1'b0, v);
         if (disturb && i == BW)     drive(sel, 1'b1, 8'd99);
         if (disturb && i == BW + 1) drive(sel, 1'b0, v);
      end
      if (disturb) begin
         for (int i = 0; i < 4; i++) begin
            @(negedge CLK);
            got_busy = sel ? busy_b : busy_a;
            vectors++;
            if (got_busy !== 1'b0) begin
               miscompares++;
               $display("FAIL %s stray restart cycle %0d: busy got %b want 0", tag, i, got_busy);
            end
         end
      end
      lc1 = sel ? load_cnt_b : load_cnt_a;
      vectors++;
      if (lc1 - lc0 !== 1) begin
         miscompares++;
         $display("FAIL %s load pulses: got %0d want 1", tag, lc1 - lc0);
      end
   endtask

   task automatic test_reset();
      #23;
      vectors++;
      if ({busy_a, load_a, ovf_a, bcd_a} !== 15'd0) begin
         miscompares++;
         $display("FAIL reset_a outputs: got %h want 0", {busy_a, load_a, ovf_a, bcd_a});
      end
      vectors++;
      if ({busy_b, load_b, ovf_b, bcd_b} !== 11'd0) begin
         miscompares++;
         $display("FAIL reset_b outputs: got %h want 0", {busy_b, load_b, ovf_b, bcd_b});
      end
      @(negedge CLK);
      RST = 1'b1;
      @(negedge CLK);
   endtask

   task automatic test_basic();
      run_conv(1'b0, 8'd255, 1'b0, "basic255");
      run_conv(1'b0, 8'd0,   1'b0, "basic0");
      run_conv(1'b0, 8'd9,   1'b0, "basic9");
      run_conv(1'b0, 8'd100, 1'b0, "basic100");
   endtask

   task automatic test_overflow();
      run_conv(1'b1, 8'd200, 1'b0, "ovf200");
      run_conv(1'b1, 8'd42,  1'b0, "ovf42");
      run_conv(1'b1, 8'd99,  1'b0, "ovf99");
      run_conv(1'b1, 8'd100, 1'b0, "ovf100");
   endtask

   task automatic test_ignored_start();
      run_conv(1'b0, 8'd17, 1'b1, "ignored17");
   endtask

   // Start held high: a conversion is accepted every BW+2 edges, each one
   // taking whatever BinValue is present at its accepting edge
   task automatic test_held_start();
      logic [7:0]  accepted[$];
      logic [11:0] exp_bcd;
      bit          exp_ovf;
      int          k;
      k = 0;
      bin_a   = 8'($urandom);
      start_a = 1'b1;
      accepted.push_back(bin_a);
      for (int c = 0; c < 3 * (BW + 2); c++) begin
         @(negedge CLK);
         vectors++;
         if (load_a !== ((c % (BW + 2)) == BW)) begin
            miscompares++;
            $display("FAIL held load cycle %0d: got %b want %b", c, load_a, ((c % (BW + 2)) == BW));
         end
         if ((c % (BW + 2)) == BW) begin
            exp_bcd = ref_bcd(int'(accepted[k]), 3, exp_ovf);
            k++;
            vectors++;
            if (bcd_a !== exp_bcd) begin
               miscompares++;
               $display("FAIL held bcd %0d: got %h want %h", k, bcd_a, exp_bcd);
            end
         end
         bin_a = 8'($urandom);
         if ((c % (BW + 2)) == BW + 1) accepted.push_back(bin_a);
      end
      start_a = 1'b0;
      // the last push was for a conversion now in flight; let it drain
      for (int c = 0; c < BW + 2; c++) @(negedge CLK);
   endtask

   task automatic test_async_reset();
      int lc0;
      run_conv(1'b0, 8'd123, 1'b0, "pre_reset");
      lc0 = load_cnt_a;
      drive(1'b0, 1'b1, 8'd201);
      for (int i = 0; i < 4; i++) begin
         @(negedge CLK);
         start_a = 1'b0;
      end
      #2 RST = 1'b0;
      #1;
      vectors++;
      if ({busy_a, load_a, ovf_a, bcd_a} !== 15'd0) begin
         miscompares++;
         $display("FAIL async_reset outputs: got %h want 0", {busy_a, load_a, ovf_a, bcd_a});
      end
      @(negedge CLK);
      @(negedge CLK);
      RST = 1'b1;
      for (int i = 0; i < BW + 2; i++) begin
         @(negedge CLK);
         vectors++;
         if (busy_a !== 1'b0 || load_a !== 1'b0) begin
            miscompares++;
            $display("FAIL after_reset cycle %0d: busy %b load %b want 0 0", i, busy_a, load_a);
         end
      end
      vectors++;
      if (load_cnt_a !== lc0) begin
         miscompares++;
         $display("FAIL aborted load pulses: got %0d want %0d", load_cnt_a - lc0, 0);
      end
      run_conv(1'b0, 8'd58, 1'b0, "post_reset58");
   endtask

   task automatic test_random();
      for (int n = 0; n < 30; n++) begin
         run_conv(1'b0, 8'($urandom), 1'b0, "rand_a");
         run_conv(1'b1, 8'($urandom), 1'b0, "rand_b");
      end
   endtask

   task automatic test_invariants();
      vectors++;
      if (dbl_load !== 0) begin
         miscompares++;
         $display("FAIL consecutive_load: got %0d want 0", dbl_load);
      end
      vectors++;
      if (bad_chg !== 0) begin
         miscompares++;
         $display("FAIL bcd_change_without_load: got %0d want 0", bad_chg);
      end
   endtask

   initial begin
      test_reset();
      test_basic();
      test_overflow();
      test_ignored_start();
      test_held_start();
      test_async_reset();
      test_random();
      test_invariants();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
